cps2_mode_sequencer: RTL and testbench



---
 rtl/cps2_mode_pkg.sv | 43 ++++
 rtl/cps2_mode_lut.sv | 49 ++++
 rtl/cps2_mode_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_cps2_mode_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cps2_mode_pkg.sv
// rtl/cps2_mode_pkg.sv - shared encodings, preset table and timing match helper
package cps2_mode_pkg;

  localparam int MODE_NUM  = 3;
  localparam int MODE_ID_W = 3;
  localparam int CFG_ID_W  = 5;

  typedef enum logic [1:0] {
    ST_NOSYNC  = 2'd0,
    ST_LOCKING = 2'd1,
    ST_MUTE    = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  typedef struct packed {
    logic [9:0]          h_total;
    logic [9:0]          v_total;
    logic [CFG_ID_W-1:0] cfg_id;
  } preset_t;

  function automatic preset_t preset_at(input int idx);
    preset_t p;
    case (idx)
      1:       p = '{h_total: 10'd512, v_total: 10'd262, cfg_id: 5'd1};
      2:       p = '{h_total: 10'd512, v_total: 10'd263, cfg_id: 5'd2};
      3:       p = '{h_total: 10'd454, v_total: 10'd262, cfg_id: 5'd3};
      default: p = '0;
    endcase
    return p;
  endfunction

  // h may drift by +/-tol between frames; v is a line count and must be exact
  function automatic logic timing_match(input logic [9:0] h, input logic [9:0] v,
                                        input logic [9:0] ref_h, input logic [9:0] ref_v,
                                        input int tol);
    logic signed [10:0] d;
    logic signed [10:0] t;
    d = $signed({1'b0, h}) - $signed({1'b0, ref_h});
    t = 11'(tol);
    return (d <= t) && (d >= -t) && (v == ref_v);
  endfunction

endpackage

// File: rtl/cps2_mode_lut.sv
// rtl/cps2_mode_lut.sv - registered preset lookup, lowest matching index wins
module cps2_mode_lut
  import cps2_mode_pkg::*;
#(
  parameter int H_TOL = 2
) (
  input  logic                 PCLK_i,
  input  logic                 reset,
  input  logic                 req,
  input  logic [9:0]           h_total,
  input  logic [9:0]           v_total,
  output logic                 valid,
  output logic [MODE_ID_W-1:0] mode_id,
  output logic [CFG_ID_W-1:0]  cfg_id
);

  logic [MODE_ID_W-1:0] hit_id;
  logic [CFG_ID_W-1:0]  hit_cfg;
  preset_t              p;

  // scan downwards so the lowest matching index is the one left standing
  always_comb begin
    hit_id  = '0;
    hit_cfg = '0;
    p       = '0;
    for (int i = MODE_NUM; i >= 1; i--) begin
      p = preset_at(i);
      if (timing_match(h_total, v_total, p.h_total, p.v_total, H_TOL)) begin
        hit_id  = MODE_ID_W'(i);
        hit_cfg = p.cfg_id;
      end
    end
  end

  always_ff @(posedge PCLK_i) begin
    if (reset) begin
      valid   <= 1'b0;
      mode_id <= '0;
      cfg_id  <= '0;
    end else begin
      valid <= req;
      if (req) begin
        mode_id <= hit_id;
        cfg_id  <= hit_cfg;
      end
    end
  end

endmodule

// File: rtl/cps2_mode_sequencer.sv
// rtl/cps2_mode_sequencer.sv - video mode lock/mute sequencer with frame watchdog
module cps2_mode_sequencer
  import cps2_mode_pkg::*;
#(
  parameter int LOCK_FRAMES    = 4,
  parameter int UNLOCK_FRAMES  = 3,
  parameter int BLANK_FRAMES   = 2,
  parameter int H_TOL          = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                 PCLK_i,
  input  logic                 reset,
  input  logic                 frame_change_i,
  input  logic [9:0]           h_total_i,
  input  logic [9:0]           v_total_i,
  output logic                 mode_valid_o,
  output logic [MODE_ID_W-1:0] mode_id_o,
  output logic [CFG_ID_W-1:0]  mclk_cfg_id_o,
  output logic                 blank_o,
  output logic                 mode_changed_o,
  output logic [1:0]           state_o
);

  localparam int MC_W = $clog2(LOCK_FRAMES + 1);
  localparam int MS_W = $clog2(UNLOCK_FRAMES + 1);
  localparam int BC_W = $clog2(BLANK_FRAMES + 2);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [MC_W-1:0] MC_LOCK   = MC_W'(LOCK_FRAMES);
  localparam logic [MC_W-1:0] MC_ONE    = MC_W'(1);
  localparam logic [MS_W-1:0] MS_UNLOCK = MS_W'(UNLOCK_FRAMES);
  localparam logic [BC_W-1:0] BC_BLANK  = BC_W'(BLANK_FRAMES);
  localparam logic [BC_W-1:0] BC_ONE    = BC_W'(1);
  localparam logic [WD_W-1:0] WD_MAX    = WD_W'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_nxt;
  logic [9:0]           ref_h_q, ref_h_nxt, ref_v_q, ref_v_nxt;
  logic [MC_W-1:0]      match_cnt_q, match_cnt_nxt;
  logic [MS_W-1:0]      miss_cnt_q, miss_cnt_nxt, miss_inc;
  logic [BC_W-1:0]      blank_cnt_q, blank_cnt_nxt;
  logic [WD_W-1:0]      wd_q, wd_nxt, wd_inc;
  logic                 req_sent_q, req_sent_nxt;
  logic                 valid_q, valid_nxt, blank_q, blank_nxt;
  logic                 changed_q, changed_nxt;
  logic [MODE_ID_W-1:0] id_q, id_nxt, id_d_q;
  logic [CFG_ID_W-1:0]  cfg_q, cfg_nxt;
  logic                 match, expire, lut_req, lut_valid;
  logic [MODE_ID_W-1:0] lut_id;
  logic [CFG_ID_W-1:0]  lut_cfg;

  cps2_mode_lut #(.H_TOL(H_TOL)) u_lut (
    .PCLK_i  (PCLK_i),
    .reset   (reset),
    .req     (lut_req),
    .h_total (ref_h_q),
    .v_total (ref_v_q),
    .valid   (lut_valid),
    .mode_id (lut_id),
    .cfg_id  (lut_cfg)
  );

  assign match    = timing_match(h_total_i, v_total_i, ref_h_q, ref_v_q, H_TOL);
  assign wd_inc   = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
  assign miss_inc = miss_cnt_q + MS_W'(1);
  // a strobe landing on the expiry cycle clears the counter and wins
  assign expire   = (state_q != ST_NOSYNC) && !frame_change_i && (wd_inc == WD_MAX);
  assign lut_req  = (state_q == ST_LOCKING) && (match_cnt_q == MC_LOCK) && !req_sent_q;

  always_comb begin
    state_nxt     = state_q;
    ref_h_nxt     = ref_h_q;
    ref_v_nxt     = ref_v_q;
    match_cnt_nxt = match_cnt_q;
    miss_cnt_nxt  = miss_cnt_q;
    blank_cnt_nxt = blank_cnt_q;
    req_sent_nxt  = req_sent_q | lut_req;
    valid_nxt     = valid_q;
    id_nxt        = id_q;
    cfg_nxt       = cfg_q;
    blank_nxt     = blank_q;
    wd_nxt        = frame_change_i ? '0 : wd_inc;
    changed_nxt   = (id_q != id_d_q);
    if (expire) begin
      state_nxt     = ST_NOSYNC;
      ref_h_nxt     = '0;
      ref_v_nxt     = '0;
      match_cnt_nxt = '0;
      miss_cnt_nxt  = '0;
      blank_cnt_nxt = '0;
      req_sent_nxt  = 1'b0;
      valid_nxt     = 1'b0;
      id_nxt        = '0;
      cfg_nxt       = '0;
      blank_nxt     = 1'b1;
    end else begin
      case (state_q)
        ST_NOSYNC: begin
          if (frame_change_i) begin
            ref_h_nxt     = h_total_i;
            ref_v_nxt     = v_total_i;
            match_cnt_nxt = MC_ONE;
            req_sent_nxt  = 1'b0;
            state_nxt     = ST_LOCKING;
          end
        end
        ST_LOCKING: begin
          if (frame_change_i && !match) begin
            ref_h_nxt     = h_total_i;
            ref_v_nxt     = v_total_i;
            match_cnt_nxt = MC_ONE;
            req_sent_nxt  = 1'b0;
          end else begin
            if (frame_change_i && match_cnt_q != MC_LOCK)
              match_cnt_nxt = match_cnt_q + MC_ONE;
            if (lut_valid && match_cnt_q == MC_LOCK) begin
              valid_nxt = 1'b1;
              id_nxt    = lut_id;
              cfg_nxt   = lut_cfg;
              if (BLANK_FRAMES == 0) begin
                blank_nxt    = 1'b0;
                miss_cnt_nxt = '0;
                state_nxt    = ST_LOCKED;
              end else begin
                blank_cnt_nxt = BC_BLANK;
                state_nxt     = ST_MUTE;
              end
            end
          end
        end
        ST_MUTE: begin
          if (frame_change_i && match) begin
            if (blank_cnt_q <= BC_ONE) begin
              blank_cnt_nxt = '0;
              blank_nxt     = 1'b0;
              miss_cnt_nxt  = '0;
              state_nxt     = ST_LOCKED;
            end else begin
              blank_cnt_nxt = blank_cnt_q - BC_ONE;
            end
          end else if (frame_change_i) begin
            valid_nxt     = 1'b0;
            id_nxt        = '0;
            cfg_nxt       = '0;
            ref_h_nxt     = h_total_i;
            ref_v_nxt     = v_total_i;
            match_cnt_nxt = MC_ONE;
            req_sent_nxt  = 1'b0;
            state_nxt     = ST_LOCKING;
          end
        end
        ST_LOCKED: begin
          if (frame_change_i && match) begin
            miss_cnt_nxt = '0;
          end else if (frame_change_i && miss_inc >= MS_UNLOCK) begin
            valid_nxt     = 1'b0;
            id_nxt        = '0;
            cfg_nxt       = '0;
            blank_nxt     = 1'b1;
            ref_h_nxt     = h_total_i;
            ref_v_nxt     = v_total_i;
            match_cnt_nxt = MC_ONE;
            miss_cnt_nxt  = '0;
            req_sent_nxt  = 1'b0;
            state_nxt     = ST_LOCKING;
          end else if (frame_change_i) begin
            miss_cnt_nxt = miss_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge PCLK_i) begin
    if (reset) begin
      state_q     <= ST_NOSYNC;
      ref_h_q     <= '0;
      ref_v_q     <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      blank_cnt_q <= '0;
      wd_q        <= '0;
      req_sent_q  <= 1'b0;
      valid_q     <= 1'b0;
      id_q        <= '0;
      id_d_q      <= '0;
      cfg_q       <= '0;
      blank_q     <= 1'b1;
      changed_q   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      ref_h_q     <= ref_h_nxt;
      ref_v_q     <= ref_v_nxt;
      match_cnt_q <= match_cnt_nxt;
      miss_cnt_q  <= miss_cnt_nxt;
      blank_cnt_q <= blank_cnt_nxt;
      wd_q        <= wd_nxt;
      req_sent_q  <= req_sent_nxt;
      valid_q     <= valid_nxt;
      id_q        <= id_nxt;
      id_d_q      <= id_q;
      cfg_q       <= cfg_nxt;
      blank_q     <= blank_nxt;
      changed_q   <= changed_nxt;
    end
  end

  assign state_o        = state_q;
  assign mode_valid_o   = valid_q;
  assign mode_id_o      = id_q;
  assign mclk_cfg_id_o  = cfg_q;
  assign blank_o        = blank_q;
  assign mode_changed_o = changed_q;

endmodule

// File: tb/tb_cps2_mode_sequencer.sv
// tb/tb_cps2_mode_sequencer.sv - directed self-checking bench for cps2_mode_sequencer
module tb_cps2_mode_sequencer;

  logic       clk;
  logic       reset;
  logic       fc;
  logic [9:0] h;
  logic [9:0] v;
  logic       mode_valid;
  logic [2:0] mode_id;
  logic [4:0] mclk_cfg;
  logic       blank;
  logic       changed;
  logic [1:0] state;
  logic [11:0] obs;
  int errors;
  int checks;

  // obs = {valid, mode_id, cfg, blank, state}
  assign obs = {mode_valid, mode_id, mclk_cfg, blank, state};

  cps2_mode_sequencer #(.TIMEOUT_CYCLES(1000)) dut (
    .PCLK_i         (clk),
    .reset          (reset),
    .frame_change_i (fc),
    .h_total_i      (h),
    .v_total_i      (v),
    .mode_valid_o   (mode_valid),
    .mode_id_o      (mode_id),
    .mclk_cfg_id_o  (mclk_cfg),
    .blank_o        (blank),
    .mode_changed_o (changed),
    .state_o        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // called at a negedge; the strobe is sampled by the next posedge
  task automatic strobe(input logic [9:0] hh, input logic [9:0] vv);
    fc = 1'b1;
    h  = hh;
    v  = vv;
    @(negedge clk);
    fc = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fc    = 1'b0;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic lock_to_locked(input logic [9:0] hh, input logic [9:0] vv);
    for (int i = 0; i < 4; i++) begin
      strobe(hh, vv);
      idle(5);
    end
    for (int i = 0; i < 2; i++) begin
      strobe(hh, vv);
      idle(3);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fc    = 1'b0;
    h     = '0;
    v     = '0;
    idle(3);
    checks++;
    if (obs !== 12'b0_000_00000_1_00) begin
      errors++;
      $display("FAIL reset_values: got %h want %h", obs, 12'b0_000_00000_1_00);
    end
    checks++;
    if (changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_changed: got %b want 0", changed);
    end
    reset = 1'b0;
    idle(5);
    checks++;
    if (obs !== 12'b0_000_00000_1_00) begin
      errors++;
      $display("FAIL idle_nosync: got %h want %h", obs, 12'b0_000_00000_1_00);
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      strobe(10'd512, 10'd262);
      idle(5);
    end
    strobe(10'd512, 10'd262);
    idle(1);
    checks++;
    if (obs !== {1'b0, 3'd0, 5'd0, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL lock_latency1: got %h want %h", obs, {1'b0, 3'd0, 5'd0, 1'b1, 2'd1});
    end
    idle(1);
    checks++;
    if (obs !== {1'b1, 3'd1, 5'd1, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL lock_mode1: got %h want %h", obs, {1'b1, 3'd1, 5'd1, 1'b1, 2'd2});
    end
    checks++;
    if (changed !== 1'b0) begin
      errors++;
      $display("FAIL lock_changed_early: got %b want 0", changed);
    end
    idle(1);
    checks++;
    if (changed !== 1'b1) begin
      errors++;
      $display("FAIL lock_changed_pulse: got %b want 1", changed);
    end
    idle(1);
    checks++;
    if (changed !== 1'b0) begin
      errors++;
      $display("FAIL lock_changed_end: got %b want 0", changed);
    end
    idle(3);
    strobe(10'd512, 10'd262);
    checks++;
    if (obs !== {1'b1, 3'd1, 5'd1, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL mute_first: got %h want %h", obs, {1'b1, 3'd1, 5'd1, 1'b1, 2'd2});
    end
    idle(3);
    strobe(10'd512, 10'd262);
    checks++;
    if (obs !== {1'b1, 3'd1, 5'd1, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL locked_unblank: got %h want %h", obs, {1'b1, 3'd1, 5'd1, 1'b0, 2'd3});
    end
  endtask

  task automatic test_tolerance();
    do_reset();
    strobe(10'd511, 10'd262); idle(5);
    strobe(10'd513, 10'd262); idle(5);
    strobe(10'd511, 10'd262); idle(5);
    strobe(10'd513, 10'd262); idle(2);
    checks++;
    if (obs !== {1'b1, 3'd1, 5'd1, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL tol_lock: got %h want %h", obs, {1'b1, 3'd1, 5'd1, 1'b1, 2'd2});
    end
    idle(3);
    strobe(10'd513, 10'd262); idle(3);
    strobe(10'd511, 10'd262); idle(3);
    strobe(10'd515, 10'd262);
    checks++;
    if (obs !== {1'b1, 3'd1, 5'd1, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL tol_single_miss: got %h want %h", obs, {1'b1, 3'd1, 5'd1, 1'b0, 2'd3});
    end
    idle(3);
    strobe(10'd512, 10'd262); idle(3);
    strobe(10'd515, 10'd262); idle(3);
    strobe(10'd515, 10'd262);
    checks++;
    if (obs !== {1'b1, 3'd1, 5'd1, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL tol_miss_cleared: got %h want %h", obs, {1'b1, 3'd1, 5'd1, 1'b0, 2'd3});
    end
    idle(3);
    strobe(10'd515, 10'd262);
    checks++;
    if (obs !== {1'b0, 3'd0, 5'd0, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL tol_unlock: got %h want %h", obs, {1'b0, 3'd0, 5'd0, 1'b1, 2'd1});
    end
    // ref is now 515; 512 is 3 away and must restart the attempt
    for (int i = 0; i < 3; i++) begin
      idle(3);
      strobe(10'd512, 10'd262);
    end
    idle(4);
    checks++;
    if (obs !== {1'b0, 3'd0, 5'd0, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL tol_delta3_restart: got %h want %h", obs, {1'b0, 3'd0, 5'd0, 1'b1, 2'd1});
    end
    strobe(10'd512, 10'd262);
    idle(2);
    checks++;
    if (obs !== {1'b1, 3'd1, 5'd1, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL tol_relock: got %h want %h", obs, {1'b1, 3'd1, 5'd1, 1'b1, 2'd2});
    end
  endtask

  task automatic test_unlock();
    do_reset();
    lock_to_locked(10'd512, 10'd262);
    checks++;
    if (obs !== {1'b1, 3'd1, 5'd1, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL unlock_pre: got %h want %h", obs, {1'b1, 3'd1, 5'd1, 1'b0, 2'd3});
    end
    strobe(10'd454, 10'd262); idle(3);
    strobe(10'd454, 10'd262); idle(3);
    checks++;
    if (obs !== {1'b1, 3'd1, 5'd1, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL unlock_two_miss: got %h want %h", obs, {1'b1, 3'd1, 5'd1, 1'b0, 2'd3});
    end
    strobe(10'd454, 10'd262);
    checks++;
    if (obs !== {1'b0, 3'd0, 5'd0, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL unlock_third: got %h want %h", obs, {1'b0, 3'd0, 5'd0, 1'b1, 2'd1});
    end
    idle(1);
    checks++;
    if (changed !== 1'b1) begin
      errors++;
      $display("FAIL unlock_changed_to0: got %b want 1", changed);
    end
    idle(3);
    strobe(10'd454, 10'd262); idle(3);
    strobe(10'd454, 10'd262); idle(3);
    strobe(10'd454, 10'd262); idle(2);
    checks++;
    if (obs !== {1'b1, 3'd3, 5'd3, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL unlock_mode3: got %h want %h", obs, {1'b1, 3'd3, 5'd3, 1'b1, 2'd2});
    end
    idle(1);
    checks++;
    if (changed !== 1'b1) begin
      errors++;
      $display("FAIL unlock_changed_to3: got %b want 1", changed);
    end
  endtask

  task automatic test_mode2();
    do_reset();
    lock_to_locked(10'd512, 10'd263);
    checks++;
    if (obs !== {1'b1, 3'd2, 5'd2, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL mode2_lock: got %h want %h", obs, {1'b1, 3'd2, 5'd2, 1'b0, 2'd3});
    end
  endtask

  task automatic test_unknown();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      strobe(10'd600, 10'd300);
      if (changed) pulses++;
      idle(5);
      if (changed) pulses++;
    end
    checks++;
    if (obs !== {1'b1, 3'd0, 5'd0, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL unknown_lock: got %h want %h", obs, {1'b1, 3'd0, 5'd0, 1'b1, 2'd2});
    end
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (changed) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL unknown_no_pulse: got %0d want 0", pulses);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    lock_to_locked(10'd512, 10'd262);
    strobe(10'd512, 10'd262);
    idle(998);
    checks++;
    if (obs !== {1'b1, 3'd1, 5'd1, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL wd_before_expiry: got %h want %h", obs, {1'b1, 3'd1, 5'd1, 1'b0, 2'd3});
    end
    idle(1);
    checks++;
    if (obs !== {1'b0, 3'd0, 5'd0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL wd_expiry: got %h want %h", obs, {1'b0, 3'd0, 5'd0, 1'b1, 2'd0});
    end
    idle(1);
    checks++;
    if (changed !== 1'b1) begin
      errors++;
      $display("FAIL wd_changed: got %b want 1", changed);
    end
    lock_to_locked(10'd512, 10'd262);
    strobe(10'd512, 10'd262);
    idle(998);
    strobe(10'd512, 10'd262);
    checks++;
    if (obs !== {1'b1, 3'd1, 5'd1, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL wd_strobe_at_expiry: got %h want %h", obs, {1'b1, 3'd1, 5'd1, 1'b0, 2'd3});
    end
    idle(997);
    checks++;
    if (state !== 2'd3) begin
      errors++;
      $display("FAIL wd_rearmed: got %0d want 3", state);
    end
  endtask

  task automatic test_reset_mid_mute();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      strobe(10'd512, 10'd262);
      if (i < 3) idle(5);
    end
    idle(2);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL rst_mute_reached: got %0d want 2", state);
    end
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    checks++;
    if ({obs, changed} !== {12'b0_000_00000_1_00, 1'b0}) begin
      errors++;
      $display("FAIL rst_mute_values: got %h want %h", {obs, changed}, {12'b0_000_00000_1_00, 1'b0});
    end
    for (int i = 0; i < 3; i++) begin
      strobe(10'd512, 10'd262);
      idle(5);
    end
    checks++;
    if (obs !== {1'b0, 3'd0, 5'd0, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL rst_three_frames: got %h want %h", obs, {1'b0, 3'd0, 5'd0, 1'b1, 2'd1});
    end
    strobe(10'd512, 10'd262);
    idle(2);
    checks++;
    if (obs !== {1'b1, 3'd1, 5'd1, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL rst_relock: got %h want %h", obs, {1'b1, 3'd1, 5'd1, 1'b1, 2'd2});
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_lock();
    test_tolerance();
    test_unlock();
    test_mode2();
    test_unknown();
    test_watchdog();
    test_reset_mid_mute();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
